// File: rtl/seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_muldiv : sequential signed 32x32 Booth multiplier / non-restoring      |
// |              divider. Divide path present only with MULDIV_DIV_EN defined. |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module seq_muldiv (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        div_by_zero
);

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   qr_q, qr_d;
  logic [W-1:0]   m_q, m_d;
  logic           qm1_q, qm1_d;
  logic [2*W-1:0] result_q, result_d;

  logic [W:0]     booth_sum;
  logic [W:0]     booth_acc;
  logic [W-1:0]   booth_qr;

  // acc is one bit wider than the operand so adding/subtracting -2^31 cannot overflow.
  always_comb begin
    booth_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + {m_q[W-1], m_q};
      2'b10:   booth_sum = acc_q - {m_q[W-1], m_q};
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[W], booth_sum[W:1]};
    booth_qr  = {booth_sum[0], qr_q[W-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic         rneg_q, rneg_d;
  logic         qneg_q, qneg_d;
  logic         dbz_q, dbz_d;
  logic [W:0]   div_shift;
  logic [W:0]   div_r;
  logic [W-1:0] rem_mag;
  logic [W-1:0] rem_s;
  logic [W-1:0] quo_s;
  logic [W-1:0] a_rec;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // Partial remainder stays within [-D, D), so dropping acc's top bit before the shift is safe.
  always_comb begin
    div_shift = {acc_q[W-1:0], qr_q[W-1]};
    div_r     = acc_q[W] ? div_shift + {1'b0, m_q} : div_shift - {1'b0, m_q};
    rem_mag   = acc_q[W] ? acc_q[W-1:0] + m_q : acc_q[W-1:0];
    rem_s     = rneg_q ? -rem_mag : rem_mag;
    quo_s     = qneg_q ? -qr_q : qr_q;
    a_rec     = rneg_q ? -qr_q : qr_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    rneg_d   = rneg_q;
    qneg_d   = qneg_q;
    dbz_d    = 1'b0;
`endif
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (!op) begin
            state_d = MUL;
            qr_d    = b_in;
            m_d     = a_in;
          end else begin
`ifdef MULDIV_DIV_EN
            state_d = DIV;
            qr_d    = mag(a_in);
            m_d     = mag(b_in);
            rneg_d  = a_in[W-1];
            qneg_d  = a_in[W-1] ^ b_in[W-1];
`else
            state_d  = FIN;
            qr_d     = '0;
            m_d      = '0;
            result_d = '0;
`endif
          end
        end
      end
      MUL: begin
        acc_d = booth_acc;
        qr_d  = booth_qr;
        qm1_d = qr_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = FIN;
          result_d = {booth_acc[W-1:0], booth_qr};
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (m_q == '0) begin
          state_d  = FIN;
          result_d = {a_rec, {W{1'b1}}};
          dbz_d    = 1'b1;
        end else if (cnt_q == 6'd32) begin
          state_d  = FIN;
          result_d = {rem_s, quo_s};
        end else begin
          acc_d = div_r;
          qr_d  = {qr_q[W-2:0], ~div_r[W]};
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIV_EN
      rneg_q   <= 1'b0;
      qneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
`ifdef MULDIV_DIV_EN
      rneg_q   <= rneg_d;
      qneg_q   <= qneg_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign done   = (state_q == FIN);
  assign result = result_q;
`ifdef MULDIV_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire
